branch_resolve_pred: RTL and testbench

//  Next-generation branch compare unit for the pipelined MIPS core: resolves all conditional branches
//  (BEQ/BNE/BLEZ/BGTZ/BLTZ/BGEZ/BLTZAL/BGEZAL) in decode on DW-bit operands and adds a 2-bit saturating

---
 rtl/branch_resolve_pred.sv | 139 +++++++++++++
 tb/tb_branch_resolve_pred.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_resolve_pred.sv
// Decode-stage branch resolution with a 2-bit saturating BHT for fetch prediction,
// mispredict detection and saturating branch/mispredict statistics.
module branch_resolve_pred #(
  parameter int DW        = 32,
  parameter int BHT_DEPTH = 64,
  parameter int CNT_W     = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      pc_f,
  output logic             pred_taken_f,
  input  logic             valid_d,
  input  logic             stall_d,
  input  logic [5:0]       op,
  input  logic [4:0]       rt,
  input  logic [DW-1:0]    a,
  input  logic [DW-1:0]    b,
  input  logic [31:0]      pc_d,
  input  logic             pred_taken_d,
  output logic             is_branch_d,
  output logic             taken_d,
  output logic             link_d,
  output logic             mispredict_d,
  input  logic             clr_stats,
  output logic [CNT_W-1:0] br_cnt,
  output logic [CNT_W-1:0] miss_cnt
);

  localparam int IDX_W = $clog2(BHT_DEPTH);

  localparam logic [5:0] OP_REGIMM = 6'b000001;
  localparam logic [5:0] OP_BEQ    = 6'b000100;
  localparam logic [5:0] OP_BNE    = 6'b000101;
  localparam logic [5:0] OP_BLEZ   = 6'b000110;
  localparam logic [5:0] OP_BGTZ   = 6'b000111;

  localparam logic [4:0] RT_BLTZ   = 5'b00000;
  localparam logic [4:0] RT_BGEZ   = 5'b00001;
  localparam logic [4:0] RT_BLTZAL = 5'b10000;
  localparam logic [4:0] RT_BGEZAL = 5'b10001;

  logic             a_neg;
  logic             a_zero;
  logic             a_eq_b;
  logic             resolve;

  logic [1:0]       bht [BHT_DEPTH];
  logic [IDX_W-1:0] idx_f;
  logic [IDX_W-1:0] idx_d;

  logic             upd_v;
  logic [IDX_W-1:0] upd_idx;
  logic             upd_tk;
  logic [1:0]       cur_ctr;
  logic [1:0]       new_ctr;

  logic             unused_pc;

  // Signed compares against zero reduce to sign bit and zero detect.
  assign a_neg  = a[DW-1];
  assign a_zero = (a == '0);
  assign a_eq_b = (a == b);

  always_comb begin
    is_branch_d = 1'b0;
    taken_d     = 1'b0;
    link_d      = 1'b0;
    case (op)
      OP_BEQ:  begin is_branch_d = 1'b1; taken_d = a_eq_b;            end
      OP_BNE:  begin is_branch_d = 1'b1; taken_d = ~a_eq_b;           end
      OP_BLEZ: begin is_branch_d = 1'b1; taken_d = a_neg | a_zero;    end
      OP_BGTZ: begin is_branch_d = 1'b1; taken_d = ~a_neg & ~a_zero;  end
      OP_REGIMM: begin
        case (rt)
          RT_BLTZ:   begin is_branch_d = 1'b1; taken_d = a_neg;                end
          RT_BGEZ:   begin is_branch_d = 1'b1; taken_d = ~a_neg;               end
          RT_BLTZAL: begin is_branch_d = 1'b1; taken_d = a_neg;  link_d = 1'b1; end
          RT_BGEZAL: begin is_branch_d = 1'b1; taken_d = ~a_neg; link_d = 1'b1; end
          default:   ;
        endcase
      end
      default: ;
    endcase
  end

  assign resolve      = valid_d & is_branch_d & ~stall_d;
  assign mispredict_d = resolve & (taken_d ^ pred_taken_d);

  assign idx_f        = pc_f[IDX_W+1:2];
  assign idx_d        = pc_d[IDX_W+1:2];
  assign pred_taken_f = bht[idx_f][1];
  assign unused_pc    = ^{pc_f, pc_d};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      upd_v   <= 1'b0;
      upd_idx <= '0;
      upd_tk  <= 1'b0;
    end else begin
      upd_v   <= resolve;
      upd_idx <= idx_d;
      upd_tk  <= taken_d;
    end
  end

  assign cur_ctr = bht[upd_idx];

  always_comb begin
    new_ctr = cur_ctr;
    if (upd_tk) begin
      if (cur_ctr != 2'b11) new_ctr = cur_ctr + 2'd1;
    end else begin
      if (cur_ctr != 2'b00) new_ctr = cur_ctr - 2'd1;
    end
  end

  // Write lands one edge after capture; lookups see the old value until then.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < BHT_DEPTH; i++) bht[i] <= 2'b01;
    end else if (upd_v) begin
      bht[upd_idx] <= new_ctr;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      br_cnt   <= '0;
      miss_cnt <= '0;
    end else if (clr_stats) begin
      br_cnt   <= '0;
      miss_cnt <= '0;
    end else if (resolve) begin
      if (br_cnt != '1) br_cnt <= br_cnt + CNT_W'(1);
      if (mispredict_d && (miss_cnt != '1)) miss_cnt <= miss_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_branch_resolve_pred.sv
// Directed scoreboard bench for branch_resolve_pred, built with 4-bit stats counters
// so counter saturation is reachable quickly.
module tb_branch_resolve_pred;

  localparam int DW    = 32;
  localparam int DEPTH = 64;
  localparam int CW    = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [31:0]   pc_f;
  logic          pred_taken_f;
  logic          valid_d;
  logic          stall_d;
  logic [5:0]    op;
  logic [4:0]    rt;
  logic [DW-1:0] a;
  logic [DW-1:0] b;
  logic [31:0]   pc_d;
  logic          pred_taken_d;
  logic          is_branch_d;
  logic          taken_d;
  logic          link_d;
  logic          mispredict_d;
  logic          clr_stats;
  logic [CW-1:0] br_cnt;
  logic [CW-1:0] miss_cnt;

  int tests  = 0;
  int failed = 0;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } sb_item_t;

  sb_item_t sb[$];

  branch_resolve_pred #(.DW(DW), .BHT_DEPTH(DEPTH), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .pc_f(pc_f), .pred_taken_f(pred_taken_f),
    .valid_d(valid_d), .stall_d(stall_d), .op(op), .rt(rt), .a(a), .b(b),
    .pc_d(pc_d), .pred_taken_d(pred_taken_d), .is_branch_d(is_branch_d),
    .taken_d(taken_d), .link_d(link_d), .mispredict_d(mispredict_d),
    .clr_stats(clr_stats), .br_cnt(br_cnt), .miss_cnt(miss_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic expect_val(input string tag, input logic [31:0] v);
    sb.push_back('{tag, v});
  endtask

  task automatic check_val(input logic [31:0] obs);
    sb_item_t it;
    tests++;
    if (sb.size() == 0) begin
      failed++;
      $error("FAIL scoreboard_empty: observed %0h required an expectation", obs);
    end else begin
      it = sb.pop_front();
      assert (obs === it.val) else begin
        failed++;
        $error("FAIL %s: observed %0h expected %0h", it.tag, obs, it.val);
      end
      $display("[TB] check %s obs=%0h exp=%0h", it.tag, obs, it.val);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [5:0] o, input logic [4:0] r, input logic [DW-1:0] av,
                       input logic [DW-1:0] bv, input logic [31:0] pc, input logic pr);
    op = o; rt = r; a = av; b = bv; pc_d = pc; pred_taken_d = pr; valid_d = 1'b1;
  endtask

  // Reference decode: {is_branch, taken, link} from signed integer compares.
  function automatic logic [2:0] model(input logic [5:0] o, input logic [4:0] r,
                                       input logic [DW-1:0] av, input logic [DW-1:0] bv);
    logic signed [DW-1:0] sa;
    sa = av;
    if (o == 6'b000100) return {1'b1, av == bv, 1'b0};
    if (o == 6'b000101) return {1'b1, av != bv, 1'b0};
    if (o == 6'b000110) return {1'b1, sa <= 0, 1'b0};
    if (o == 6'b000111) return {1'b1, sa > 0, 1'b0};
    if (o == 6'b000001) begin
      if (r == 5'b00000) return {1'b1, sa < 0, 1'b0};
      if (r == 5'b00001) return {1'b1, sa >= 0, 1'b0};
      if (r == 5'b10000) return {1'b1, sa < 0, 1'b1};
      if (r == 5'b10001) return {1'b1, sa >= 0, 1'b1};
    end
    return 3'b000;
  endfunction

  logic [5:0]    op_tab [8] = '{6'b000100, 6'b000101, 6'b000110, 6'b000111,
                                6'b000001, 6'b000001, 6'b000001, 6'b000001};
  logic [4:0]    rt_tab [8] = '{5'b00000, 5'b00000, 5'b00000, 5'b00000,
                                5'b00000, 5'b00001, 5'b10000, 5'b10001};
  logic [DW-1:0] a_tab  [3] = '{32'hFFFF_FFFF, 32'h0, 32'h1};
  logic [DW-1:0] b_tab  [3] = '{32'h0, 32'h1, 32'hFFFF_FFFF};

  int exp_br;
  int exp_miss;
  logic [2:0] m;

  initial begin
    rst = 1'b1; pc_f = 32'h0; valid_d = 1'b0; stall_d = 1'b0; op = '0; rt = '0;
    a = '0; b = '0; pc_d = '0; pred_taken_d = 1'b0; clr_stats = 1'b0;
    exp_br = 0; exp_miss = 0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    expect_val("rst_pred", 0);  expect_val("rst_br", 0);  expect_val("rst_miss", 0);
    check_val(pred_taken_f);    check_val(br_cnt);        check_val(miss_cnt);
    rst = 1'b0;

    // Decode sweep (valid_d low: purely combinational)
    for (int i = 0; i < 8; i++) begin
      for (int j = 0; j < 3; j++) begin
        op = op_tab[i]; rt = rt_tab[i]; a = a_tab[j]; b = b_tab[j];
        m = model(op_tab[i], rt_tab[i], a_tab[j], b_tab[j]);
        expect_val($sformatf("dec_isbr_%0d_%0d", i, j), m[2]);
        expect_val($sformatf("dec_taken_%0d_%0d", i, j), m[1]);
        expect_val($sformatf("dec_link_%0d_%0d", i, j), m[0]);
        #1;
        check_val(is_branch_d); check_val(taken_d); check_val(link_d);
      end
    end
    op = 6'b100011; rt = 5'b00000; a = 32'h0; b = 32'h0;
    expect_val("lw_isbr", 0); expect_val("lw_taken", 0); expect_val("lw_link", 0);
    #1;
    check_val(is_branch_d); check_val(taken_d); check_val(link_d);
    op = 6'b000001; rt = 5'b00010; a = 32'hFFFF_FFFF;
    expect_val("regimm_bad_isbr", 0); expect_val("regimm_bad_taken", 0);
    #1;
    check_val(is_branch_d); check_val(taken_d);

    // Training at pc 0x40: 01 -> 10 -> 11 -> 11 (sat) -> 10 -> 01
    tick();
    pc_f = 32'h40;
    expect_val("train_init", 0);
    check_val(pred_taken_f);
    for (int k = 0; k < 6; k++) begin
      if (k < 4) drive(6'b000100, 5'd0, 32'd5, 32'd5, 32'h40, 1'b0);
      else       drive(6'b000100, 5'd0, 32'd5, 32'd6, 32'h40, 1'b0);
      expect_val($sformatf("train_mp_%0d", k), (k < 4) ? 1 : 0);
      #1;
      check_val(mispredict_d);
      @(posedge clk); #1;
      valid_d = 1'b0;
      tick();
      expect_val($sformatf("train_pred_%0d", k), (k < 5) ? 1 : 0);
      check_val(pred_taken_f);
    end
    expect_val("train_br", 6); expect_val("train_miss", 4);
    check_val(br_cnt); check_val(miss_cnt);

    // Mispredict: BNE with equal operands but predicted taken
    drive(6'b000101, 5'd0, 32'd7, 32'd7, 32'h80, 1'b1);
    expect_val("mp_flag", 1); expect_val("mp_taken", 0);
    #1;
    check_val(mispredict_d); check_val(taken_d);
    @(posedge clk); #1;
    valid_d = 1'b0;
    expect_val("mp_br", 7); expect_val("mp_miss", 5);
    check_val(br_cnt); check_val(miss_cnt);

    // Stalled: no mispredict, no count, no BHT update
    stall_d = 1'b1;
    drive(6'b000101, 5'd0, 32'd7, 32'd7, 32'h80, 1'b1);
    expect_val("stall_mp", 0);
    #1;
    check_val(mispredict_d);
    @(posedge clk); #1;
    drive(6'b000100, 5'd0, 32'd1, 32'd1, 32'hC0, 1'b0);
    tick();
    valid_d = 1'b0; stall_d = 1'b0;
    tick(); tick();
    pc_f = 32'hC0;
    expect_val("stall_br", 7); expect_val("stall_miss", 5); expect_val("stall_pred", 0);
    #1;
    check_val(br_cnt); check_val(miss_cnt); check_val(pred_taken_f);

    // Same-cycle hazard at idx 3: old value during the write cycle, new value after
    pc_f = 32'h0C;
    drive(6'b000100, 5'd0, 32'd2, 32'd2, 32'h0C, 1'b1);
    tick();
    valid_d = 1'b0;
    expect_val("hazard_old", 0);
    #1;
    check_val(pred_taken_f);
    @(posedge clk); #1;
    expect_val("hazard_new", 1); expect_val("hazard_br", 8); expect_val("hazard_miss", 5);
    check_val(pred_taken_f); check_val(br_cnt); check_val(miss_cnt);

    // Stats saturation with 4-bit counters
    clr_stats = 1'b1;
    tick();
    clr_stats = 1'b0;
    expect_val("clr_br", 0); expect_val("clr_miss", 0);
    check_val(br_cnt); check_val(miss_cnt);
    drive(6'b000100, 5'd0, 32'd3, 32'd3, 32'h100, 1'b0);
    for (int k = 0; k < 18; k++) begin
      tick();
      if (k == 13) begin
        expect_val("cnt_br_14", 14); expect_val("cnt_miss_14", 14);
        check_val(br_cnt); check_val(miss_cnt);
      end
      if (k == 14) begin
        expect_val("cnt_br_15", 15); expect_val("cnt_miss_15", 15);
        check_val(br_cnt); check_val(miss_cnt);
      end
    end
    expect_val("sat_br", 15); expect_val("sat_miss", 15);
    check_val(br_cnt); check_val(miss_cnt);
    clr_stats = 1'b1;
    tick();
    clr_stats = 1'b0;
    expect_val("clrwin_br", 0); expect_val("clrwin_miss", 0);
    check_val(br_cnt); check_val(miss_cnt);
    tick();
    valid_d = 1'b0;
    expect_val("after_clr_br", 1); expect_val("after_clr_miss", 1);
    check_val(br_cnt); check_val(miss_cnt);

    // Reset between capture and write at idx 49
    pc_f = 32'hC4;
    drive(6'b000100, 5'd0, 32'd4, 32'd4, 32'hC4, 1'b0);
    tick();
    valid_d = 1'b0;
    rst = 1'b1;
    #2;
    rst = 1'b0;
    expect_val("rstmid_br", 0); expect_val("rstmid_miss", 0); expect_val("rstmid_pred", 0);
    check_val(br_cnt); check_val(miss_cnt); check_val(pred_taken_f);
    tick(); tick();
    expect_val("rstmid_nostale", 0);
    check_val(pred_taken_f);
    pc_f = 32'h0C;
    expect_val("rstmid_idx3", 0); expect_val("rstmid_br_late", 0);
    #1;
    check_val(pred_taken_f); check_val(br_cnt);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
